// File: rtl/mccu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state codes, op/func codes, select codes.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mccu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_MEM = 3'b011,
    S_WB  = 3'b100,
    S_EXE = 3'b101,
    S_EXC = 3'b110
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operation codes
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // One-hot decoded instruction
  typedef struct packed {
    logic i_add;
    logic i_sub;
    logic i_and;
    logic i_or;
    logic i_xor;
    logic i_sll;
    logic i_srl;
    logic i_sra;
    logic i_jr;
    logic i_addi;
    logic i_andi;
    logic i_ori;
    logic i_xori;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_bne;
    logic i_lui;
    logic i_j;
    logic i_jal;
  } insn_t;

  // Flags are one-hot, so OR-ing the codes yields the code of the decoded op;
  // branches compare by XOR, loads/stores/addi fall through to ADD.
  function automatic logic [3:0] aluc_of(insn_t i);
    logic [3:0] a;
    a = ALUC_ADD;
    if (i.i_sub)                          a = a | ALUC_SUB;
    if (i.i_and  | i.i_andi)              a = a | ALUC_AND;
    if (i.i_or   | i.i_ori)               a = a | ALUC_OR;
    if (i.i_xor  | i.i_xori)              a = a | ALUC_XOR;
    if (i.i_beq  | i.i_bne)               a = a | ALUC_XOR;
    if (i.i_sll)                          a = a | ALUC_SLL;
    if (i.i_srl)                          a = a | ALUC_SRL;
    if (i.i_sra)                          a = a | ALUC_SRA;
    if (i.i_lui)                          a = a | ALUC_LUI;
    return a;
  endfunction

endpackage

// File: rtl/mccu_decode.sv
// Instruction decoder: op/func to one-hot instruction flags plus an illegal flag.
// Latency: combinational, zero cycles.
// Backpressure: none; follows IR directly.
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output insn_t      insn,
  output logic       illegal
);

  logic r_type;
  assign r_type = (op == OP_RTYPE);

  // Match every supported op/func; anything unmatched is illegal.
  always_comb begin
    insn        = '0;
    insn.i_add  = r_type & (func == FN_ADD);
    insn.i_sub  = r_type & (func == FN_SUB);
    insn.i_and  = r_type & (func == FN_AND);
    insn.i_or   = r_type & (func == FN_OR);
    insn.i_xor  = r_type & (func == FN_XOR);
    insn.i_sll  = r_type & (func == FN_SLL);
    insn.i_srl  = r_type & (func == FN_SRL);
    insn.i_sra  = r_type & (func == FN_SRA);
    insn.i_jr   = r_type & (func == FN_JR);
    insn.i_addi = (op == OP_ADDI);
    insn.i_andi = (op == OP_ANDI);
    insn.i_ori  = (op == OP_ORI);
    insn.i_xori = (op == OP_XORI);
    insn.i_lw   = (op == OP_LW);
    insn.i_sw   = (op == OP_SW);
    insn.i_beq  = (op == OP_BEQ);
    insn.i_bne  = (op == OP_BNE);
    insn.i_lui  = (op == OP_LUI);
    insn.i_j    = (op == OP_J);
    insn.i_jal  = (op == OP_JAL);
    illegal     = ~(|insn);
  end

endmodule

// File: rtl/mccu_ws.sv
// Multi-cycle MIPS control unit with memory wait states and bus timeout; MCCU_EXC_EN adds an EXC state.
// Latency: zero-wait j/jr/jal 2, branch 3, ALU 4, sw 4, lw 5 cycles; +1 per mem_ready=0 cycle.
// Backpressure: IF/MEM hold on mem_ready=0 up to TIMEOUT cycles, then abort to IF (EXC) with sticky bus_err.
module mccu_ws
  import mccu_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       wmdr,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       shift,
  output logic       alusrca,
  output logic       jal,
  output logic       sext,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [3:0] aluc,
  output logic       exc_sel,
  output logic       wepc,
  output logic       bus_err,
  output logic [2:0] state
);

`ifdef MCCU_EXC_EN
  localparam state_t FAULT_NEXT = S_EXC;
`else
  localparam state_t FAULT_NEXT = S_IF;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  insn_t            insn;
  logic             illegal;

  mccu_decode u_decode (
    .op      (op),
    .func    (func),
    .insn    (insn),
    .illegal (illegal)
  );

  assign state   = state_q;
  assign mem_req = (state_q == S_IF) | (state_q == S_MEM);
  // Ready in the same cycle as the limit wins, so timeout requires ready low.
  assign timeout = mem_req & ~mem_ready & (wait_cnt == CNT_W'(TIMEOUT - 1));

  // State, wait counter and sticky bus error.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IF;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (mem_req & ~mem_ready & ~timeout) ? wait_cnt + 1'b1 : '0;
      if (timeout) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Next state and datapath controls for the current state.
  always_comb begin
    state_d  = S_IF;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    wmdr     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    shift    = 1'b0;
    alusrca  = 1'b0;
    jal      = 1'b0;
    sext     = 1'b1;
    alusrcb  = SRCB_REG;
    pcsource = PC_ALU;
    aluc     = ALUC_ADD;
    exc_sel  = 1'b0;
    wepc     = 1'b0;
    case (state_q)
      S_IF: begin
        alusrca = 1'b1;
        alusrcb = SRCB_FOUR;
        wpc     = mem_ready;
        wir     = mem_ready;
        state_d = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        if (insn.i_j | insn.i_jal) begin
          pcsource = PC_JUMP;
          wpc      = 1'b1;
          jal      = insn.i_jal;
          wreg     = insn.i_jal;
          state_d  = S_IF;
        end else if (insn.i_jr) begin
          pcsource = PC_JR;
          wpc      = 1'b1;
          state_d  = S_IF;
        end else if (illegal) begin
          state_d = FAULT_NEXT;
        end else begin
          alusrca = 1'b1;
          alusrcb = SRCB_BRANCH;
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        aluc = aluc_of(insn);
        sext = ~(insn.i_andi | insn.i_ori | insn.i_xori);
        if (insn.i_beq | insn.i_bne) begin
          pcsource = PC_BRANCH;
          wpc      = (insn.i_beq & z) | (insn.i_bne & ~z);
          state_d  = S_IF;
        end else if (insn.i_lw | insn.i_sw) begin
          alusrcb = SRCB_IMM;
          state_d = S_MEM;
        end else begin
          shift = insn.i_sll | insn.i_srl | insn.i_sra;
          if (insn.i_addi | insn.i_andi | insn.i_ori | insn.i_xori | insn.i_lui) begin
            alusrcb = SRCB_IMM;
          end
          state_d = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        wmem = insn.i_sw & mem_ready;
        wmdr = insn.i_lw & mem_ready;
        if (mem_ready) begin
          state_d = insn.i_lw ? S_WB : S_IF;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        wreg    = 1'b1;
        m2reg   = insn.i_lw;
        regrt   = insn.i_lw | insn.i_addi | insn.i_andi | insn.i_ori | insn.i_xori | insn.i_lui;
        state_d = S_IF;
      end
`ifdef MCCU_EXC_EN
      S_EXC: begin
        wepc    = 1'b1;
        exc_sel = 1'b1;
        wpc     = 1'b1;
        state_d = S_IF;
      end
`endif
      default: begin
        state_d = S_IF;
      end
    endcase
    if (timeout) begin
      state_d = FAULT_NEXT;
    end
  end

endmodule

// File: tb/tb_mccu_ws.sv
// Scoreboard bench for mccu_ws: directed per-cycle vectors with hand-derived expected controls.
// Latency: one expected entry per clock, checked at the falling edge of the same cycle.
// Backpressure: mem_ready driven low to exercise wait states, the timeout limit and reset mid-access.
module tb_mccu_ws;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       wpc;
    logic       wir;
    logic       wmem;
    logic       wreg;
    logic       wmdr;
    logic       iord;
    logic       regrt;
    logic       m2reg;
    logic       shift;
    logic       alusrca;
    logic       jal;
    logic       sext;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [3:0] aluc;
    logic       exc_sel;
    logic       wepc;
    logic       bus_err;
  } obs_t;

  logic       clock;
  logic       resetn;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_ready;
  logic       mem_req, wpc, wir, wmem, wreg, wmdr, iord;
  logic       regrt, m2reg, shift, alusrca, jal, sext;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic       exc_sel, wepc, bus_err;
  logic [2:0] state;

  obs_t  act;
  obs_t  exp_q[$];
  string name_q[$];
  int    vectors;
  int    miscompares;

  mccu_ws dut (
    .clock     (clock),
    .resetn    (resetn),
    .op        (op),
    .func      (func),
    .z         (z),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .wpc       (wpc),
    .wir       (wir),
    .wmem      (wmem),
    .wreg      (wreg),
    .wmdr      (wmdr),
    .iord      (iord),
    .regrt     (regrt),
    .m2reg     (m2reg),
    .shift     (shift),
    .alusrca   (alusrca),
    .jal       (jal),
    .sext      (sext),
    .alusrcb   (alusrcb),
    .pcsource  (pcsource),
    .aluc      (aluc),
    .exc_sel   (exc_sel),
    .wepc      (wepc),
    .bus_err   (bus_err),
    .state     (state)
  );

  assign act = {state, mem_req, wpc, wir, wmem, wreg, wmdr, iord, regrt, m2reg,
                shift, alusrca, jal, sext, alusrcb, pcsource, aluc, exc_sel, wepc, bus_err};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // State codes and instruction fields
  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EXE = 3'b101;
  localparam logic [2:0] ST_MEM = 3'b011, ST_WB = 3'b100;
`ifdef MCCU_EXC_EN
  localparam logic [2:0] ST_EXC = 3'b110;
`endif

  function automatic obs_t base(input logic [2:0] st, input logic err);
    obs_t o;
    o = '0;
    o.st = st;
    o.sext = 1'b1;
    o.bus_err = err;
    return o;
  endfunction

  function automatic obs_t e_if(input logic rdy, input logic err);
    obs_t o;
    o = base(ST_IF, err);
    o.mem_req = 1'b1;
    o.alusrca = 1'b1;
    o.alusrcb = 2'b01;
    o.wpc = rdy;
    o.wir = rdy;
    return o;
  endfunction

  function automatic obs_t e_id(input logic err);
    obs_t o;
    o = base(ST_ID, err);
    o.alusrca = 1'b1;
    o.alusrcb = 2'b11;
    return o;
  endfunction

  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic zz,
                      input logic rr, input logic rst, input obs_t e, input string nm);
    @(posedge clock);
    #1;
    resetn    = ~rst;
    op        = o;
    func      = f;
    z         = zz;
    mem_ready = rr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one expected entry is consumed per falling edge.
  initial begin
    vectors = 0;
    miscompares = 0;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        obs_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s: got %h (state %b) expected %h (state %b)", n, act, act.st, e, e.st);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d entries pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t x;
    resetn = 1'b0;
    op = 6'h00;
    func = 6'h20;
    z = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clock);

    step(6'h00, 6'h20, 0, 0, 1, e_if(0, 0), "reset_state");

    // IF stretched to exactly the limit; ready on the 15th cycle beats the timeout.
    for (int i = 0; i < 14; i++) step(6'h00, 6'h20, 0, 0, 0, e_if(0, 0), "if_wait_below_limit");
    step(6'h00, 6'h20, 0, 1, 0, e_if(1, 0), "if_ready_at_limit");

    // add
    step(6'h00, 6'h20, 0, 1, 0, e_id(0), "add_id");
    x = base(ST_EXE, 0);
    step(6'h00, 6'h20, 0, 1, 0, x, "add_exe");
    x = base(ST_WB, 0); x.wreg = 1;
    step(6'h00, 6'h20, 0, 1, 0, x, "add_wb");

    // lw with three wait states in MEM
    step(6'h23, 6'h00, 0, 1, 0, e_if(1, 0), "lw_if");
    step(6'h23, 6'h00, 0, 1, 0, e_id(0), "lw_id");
    x = base(ST_EXE, 0); x.alusrcb = 2'b10;
    step(6'h23, 6'h00, 0, 1, 0, x, "lw_exe");
    x = base(ST_MEM, 0); x.iord = 1; x.mem_req = 1;
    for (int i = 0; i < 3; i++) step(6'h23, 6'h00, 0, 0, 0, x, "lw_mem_wait");
    x.wmdr = 1;
    step(6'h23, 6'h00, 0, 1, 0, x, "lw_mem_ready");
    x = base(ST_WB, 0); x.wreg = 1; x.m2reg = 1; x.regrt = 1;
    step(6'h23, 6'h00, 0, 1, 0, x, "lw_wb");

    // beq taken (z=1)
    step(6'h04, 6'h00, 1, 1, 0, e_if(1, 0), "beq_if");
    step(6'h04, 6'h00, 1, 1, 0, e_id(0), "beq_id");
    x = base(ST_EXE, 0); x.aluc = 4'b0010; x.pcsource = 2'b01; x.wpc = 1;
    step(6'h04, 6'h00, 1, 1, 0, x, "beq_exe_taken");

    // bne not taken (z=1)
    step(6'h05, 6'h00, 1, 1, 0, e_if(1, 0), "bne_if");
    step(6'h05, 6'h00, 1, 1, 0, e_id(0), "bne_id");
    x = base(ST_EXE, 0); x.aluc = 4'b0010; x.pcsource = 2'b01;
    step(6'h05, 6'h00, 1, 1, 0, x, "bne_exe_not_taken");

    // jal
    step(6'h03, 6'h00, 0, 1, 0, e_if(1, 0), "jal_if");
    x = base(ST_ID, 0); x.pcsource = 2'b11; x.jal = 1; x.wreg = 1; x.wpc = 1;
    step(6'h03, 6'h00, 0, 1, 0, x, "jal_id");

    // ori: zero-extended immediate
    step(6'h0D, 6'h00, 0, 1, 0, e_if(1, 0), "ori_if");
    step(6'h0D, 6'h00, 0, 1, 0, e_id(0), "ori_id");
    x = base(ST_EXE, 0); x.aluc = 4'b0101; x.alusrcb = 2'b10; x.sext = 0;
    step(6'h0D, 6'h00, 0, 1, 0, x, "ori_exe");
    x = base(ST_WB, 0); x.wreg = 1; x.regrt = 1;
    step(6'h0D, 6'h00, 0, 1, 0, x, "ori_wb");

    // sra
    step(6'h00, 6'h03, 0, 1, 0, e_if(1, 0), "sra_if");
    step(6'h00, 6'h03, 0, 1, 0, e_id(0), "sra_id");
    x = base(ST_EXE, 0); x.aluc = 4'b1111; x.shift = 1;
    step(6'h00, 6'h03, 0, 1, 0, x, "sra_exe");
    x = base(ST_WB, 0); x.wreg = 1;
    step(6'h00, 6'h03, 0, 1, 0, x, "sra_wb");

    // sw zero-wait
    step(6'h2B, 6'h00, 0, 1, 0, e_if(1, 0), "sw_if");
    step(6'h2B, 6'h00, 0, 1, 0, e_id(0), "sw_id");
    x = base(ST_EXE, 0); x.alusrcb = 2'b10;
    step(6'h2B, 6'h00, 0, 1, 0, x, "sw_exe");
    x = base(ST_MEM, 0); x.iord = 1; x.mem_req = 1; x.wmem = 1;
    step(6'h2B, 6'h00, 0, 1, 0, x, "sw_mem");

    // jr
    step(6'h00, 6'h08, 0, 1, 0, e_if(1, 0), "jr_if");
    x = base(ST_ID, 0); x.pcsource = 2'b10; x.wpc = 1;
    step(6'h00, 6'h08, 0, 1, 0, x, "jr_id");

    // IF timeout: 15 stalled cycles, then bus_err sticks
    for (int i = 0; i < 15; i++) step(6'h3F, 6'h00, 0, 0, 0, e_if(0, 0), "if_stall");
`ifdef MCCU_EXC_EN
    x = base(ST_EXC, 1); x.wepc = 1; x.exc_sel = 1; x.wpc = 1;
    step(6'h3F, 6'h00, 0, 1, 0, x, "timeout_exc");
`endif
    step(6'h3F, 6'h00, 0, 1, 0, e_if(1, 1), "timeout_reenter_if");

    // Illegal opcode
    step(6'h3F, 6'h00, 0, 1, 0, base(ST_ID, 1), "illegal_id");
`ifdef MCCU_EXC_EN
    x = base(ST_EXC, 1); x.wepc = 1; x.exc_sel = 1; x.wpc = 1;
    step(6'h3F, 6'h00, 0, 1, 0, x, "illegal_exc");
`endif
    step(6'h23, 6'h00, 0, 1, 0, e_if(1, 1), "illegal_back_to_if");

    // Reset in the middle of a stalled lw access
    step(6'h23, 6'h00, 0, 1, 0, e_id(1), "lw2_id");
    x = base(ST_EXE, 1); x.alusrcb = 2'b10;
    step(6'h23, 6'h00, 0, 1, 0, x, "lw2_exe");
    x = base(ST_MEM, 1); x.iord = 1; x.mem_req = 1;
    step(6'h23, 6'h00, 0, 0, 0, x, "lw2_mem_wait");
    step(6'h23, 6'h00, 0, 1, 1, e_if(1, 0), "reset_mid_mem");
    step(6'h23, 6'h00, 0, 1, 0, e_if(1, 0), "after_reset_release");

    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
